// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, reset
// cause codes and a small constant helper used for counter sizing.
package rst_seq_pkg;

    // Sequencer phases: both resets held, peripheral released, all released.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        GAP  = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Cause of the most recent reset, as reported to the system controller.
    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    // Larger of two integers; used to size the shared phase counter.
    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/rst_seq_wdt.sv
// Watchdog counter for the reset sequencer. Counts only while the system is
// running; any kick or leaving RUN clears it. Only instantiated when the
// top level is built with RST_SEQ_WDT_EN defined.
module rst_seq_wdt #(
    parameter int WDT_CYCLES = 1048576
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_kick,
    output logic o_expire
);

    localparam int            WDT_W    = $clog2(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(32'd1);

    logic [WDT_W-1:0] cnt_q;
    logic [WDT_W-1:0] cnt_d;

    // Next count: clear outside RUN or on a kick, otherwise count up and
    // saturate at the terminal value (the sequencer leaves RUN right after).
    always_comb begin
        cnt_d = cnt_q;
        if (!i_run || i_kick) begin
            cnt_d = {WDT_W{1'b0}};
        end else if (cnt_q == WDT_LAST) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + WDT_ONE;
        end
    end

    // Watchdog count register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= {WDT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A kick in the terminal cycle beats the expiry.
    assign o_expire = i_run && !i_kick && (cnt_q == WDT_LAST);

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: releases the peripheral reset HOLD_CYCLES after the reset
// source clears, then the core reset STAGE_GAP cycles later. A software
// request (or a watchdog expiry when built with RST_SEQ_WDT_EN) restarts the
// sequence. The cause of the last reset is kept sticky in o_rst_cause.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int WDT_CYCLES  = 1048576
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sw_req,
    output logic       o_sw_ack,
    input  logic       i_wdt_kick,
    output logic       o_rst_periph,
    output logic       o_rst_core,
    output logic [1:0] o_rst_cause
);

    localparam int               CNT_W     = $clog2(max_int(HOLD_CYCLES, STAGE_GAP) + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             periph_q, periph_d;
    logic             core_q, core_d;
    logic             ack_q, ack_d;
    logic [1:0]       cause_q, cause_d;
    logic             wdt_expire_s;

`ifdef RST_SEQ_WDT_EN
    logic run_s;

    assign run_s = (state_q == RUN);

    rst_seq_wdt #(
        .WDT_CYCLES(WDT_CYCLES)
    ) u_wdt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_run   (run_s),
        .i_kick  (i_wdt_kick),
        .o_expire(wdt_expire_s)
    );
`else
    // Without the watchdog the kick input and timeout have no function.
    logic unused_wdt_s;

    assign unused_wdt_s = i_wdt_kick | (WDT_CYCLES < 2);
    assign wdt_expire_s = 1'b0;
`endif

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_q;
        core_d   = core_q;
        ack_d    = 1'b0;
        cause_d  = cause_q;
        case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d    = CNT_ZERO;
                    periph_d = 1'b0;
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = CNT_ZERO;
                    core_d  = 1'b0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (i_sw_req) begin
                    ack_d    = 1'b1;
                    cause_d  = CAUSE_SW;
                    periph_d = 1'b1;
                    core_d   = 1'b1;
                    cnt_d    = CNT_ZERO;
                    state_d  = HOLD;
                end else if (wdt_expire_s) begin
                    cause_d  = CAUSE_WDT;
                    periph_d = 1'b1;
                    core_d   = 1'b1;
                    cnt_d    = CNT_ZERO;
                    state_d  = HOLD;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a safe, fully reset state.
                periph_d = 1'b1;
                core_d   = 1'b1;
                cnt_d    = CNT_ZERO;
                state_d  = HOLD;
            end
        endcase
    end

    // State, counter and output registers; i_rst overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= HOLD;
            cnt_q    <= CNT_ZERO;
            periph_q <= 1'b1;
            core_q   <= 1'b1;
            ack_q    <= 1'b0;
            cause_q  <= CAUSE_POR;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            ack_q    <= ack_d;
            cause_q  <= cause_d;
        end
    end

    assign o_rst_periph = periph_q;
    assign o_rst_core   = core_q;
    assign o_sw_ack     = ack_q;
    assign o_rst_cause  = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq. Expected per-cycle outputs are queued as
// stimulus is applied and compared one entry per clock, sampled 1 ns after
// the rising edge. Watchdog scenarios run when RST_SEQ_WDT_EN is defined.
module tb_rst_seq;

    localparam int HOLD = 16;
    localparam int GAPC = 8;
    localparam int WDT  = 32;

    localparam logic [1:0] C_POR = 2'b00;
    localparam logic [1:0] C_SW  = 2'b01;
    localparam logic [1:0] C_WDT = 2'b10;

    typedef struct {
        logic       periph;
        logic       core;
        logic       ack;
        logic [1:0] cause;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       sw_req;
    logic       sw_ack;
    logic       wdt_kick;
    logic       rst_periph;
    logic       rst_core;
    logic [1:0] rst_cause;

    exp_t  exp_q[$];
    int    checks;
    int    failures;
    string phase;

    rst_seq #(
        .HOLD_CYCLES(HOLD),
        .STAGE_GAP  (GAPC),
        .WDT_CYCLES (WDT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sw_req    (sw_req),
        .o_sw_ack    (sw_ack),
        .i_wdt_kick  (wdt_kick),
        .o_rst_periph(rst_periph),
        .o_rst_core  (rst_core),
        .o_rst_cause (rst_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int n, input logic p, input logic c, input logic a, input logic [1:0] cause);
        exp_t e;
        e.periph = p;
        e.core   = c;
        e.ack    = a;
        e.cause  = cause;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
        end
    endtask

    // Expected outputs from the edge after a trigger until the first RUN cycle.
    task automatic push_release(input logic [1:0] cause, input int hold_done);
        push(HOLD - 1 - hold_done, 1'b1, 1'b1, 1'b0, cause);
        push(GAPC, 1'b0, 1'b1, 1'b0, cause);
        push(1, 1'b0, 1'b0, 1'b0, cause);
    endtask

    task automatic drain();
        exp_t e;
        int   n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks += 4;
            assert (rst_periph === e.periph) else begin
                failures++;
                $error("FAIL %s periph observed=%b expected=%b", phase, rst_periph, e.periph);
            end
            assert (rst_core === e.core) else begin
                failures++;
                $error("FAIL %s core observed=%b expected=%b", phase, rst_core, e.core);
            end
            assert (sw_ack === e.ack) else begin
                failures++;
                $error("FAIL %s ack observed=%b expected=%b", phase, sw_ack, e.ack);
            end
            assert (rst_cause === e.cause) else begin
                failures++;
                $error("FAIL %s cause observed=%b expected=%b", phase, rst_cause, e.cause);
            end
        end
    endtask

    task automatic one(input logic p, input logic c, input logic a, input logic [1:0] cause);
        push(1, p, c, a, cause);
        drain();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        sw_req   = 1'b0;
        wdt_kick = 1'b0;

        // Power-on: five reset edges, then the 16/24 release.
        phase = "por";
        push(5, 1'b1, 1'b1, 1'b0, C_POR);
        drain();
        rst = 1'b0;
        push_release(C_POR, 0);
        push(5, 1'b0, 1'b0, 1'b0, C_POR);
        drain();

        // Software reset: one-cycle ack with both resets rising together.
        phase = "sw";
        sw_req = 1'b1;
        one(1'b1, 1'b1, 1'b1, C_SW);
        sw_req = 1'b0;
        push_release(C_SW, 0);
        push(3, 1'b0, 1'b0, 1'b0, C_SW);
        drain();

        // Request raised during HOLD: acknowledged only in the first RUN cycle.
        phase = "req_in_seq";
        sw_req = 1'b1;
        one(1'b1, 1'b1, 1'b1, C_SW);
        sw_req = 1'b0;
        push(3, 1'b1, 1'b1, 1'b0, C_SW);
        drain();
        sw_req = 1'b1;
        push_release(C_SW, 3);
        drain();
        one(1'b1, 1'b1, 1'b1, C_SW);
        sw_req = 1'b0;
        push_release(C_SW, 0);
        drain();

`ifdef RST_SEQ_WDT_EN
        // Kicks every 20 cycles keep the system running.
        phase = "wdt_kick20";
        for (int i = 0; i < 500; i++) begin
            wdt_kick = ((i % 20) == 19);
            one(1'b0, 1'b0, 1'b0, C_SW);
        end
        // Kick on the terminal count cycle suppresses the expiry.
        phase = "wdt_coincident";
        wdt_kick = 1'b0;
        push(WDT - 1, 1'b0, 1'b0, 1'b0, C_SW);
        drain();
        wdt_kick = 1'b1;
        one(1'b0, 1'b0, 1'b0, C_SW);
        wdt_kick = 1'b0;
        push(WDT - 1, 1'b0, 1'b0, 1'b0, C_SW);
        drain();
        phase = "wdt_expire";
        one(1'b1, 1'b1, 1'b0, C_WDT);
        push_release(C_WDT, 0);
        drain();
        // No kicks: reset starts 32 cycles after entering RUN.
        phase = "wdt_nokick";
        push(WDT - 1, 1'b0, 1'b0, 1'b0, C_WDT);
        push(1, 1'b1, 1'b1, 1'b0, C_WDT);
        push_release(C_WDT, 0);
        drain();
`else
        // Watchdog absent: long idle with no kicks changes nothing.
        phase = "no_wdt_idle";
        for (int i = 0; i < 10000; i++) begin
            one(1'b0, 1'b0, 1'b0, C_SW);
        end
`endif

        // Reset pulse at GAP cnt=3 after a software reset restarts with cause 00.
        phase = "rst_mid";
        sw_req = 1'b1;
        one(1'b1, 1'b1, 1'b1, C_SW);
        sw_req = 1'b0;
        push(HOLD - 1, 1'b1, 1'b1, 1'b0, C_SW);
        push(4, 1'b0, 1'b1, 1'b0, C_SW);
        drain();
        rst = 1'b1;
        one(1'b1, 1'b1, 1'b0, C_POR);
        rst = 1'b0;
        push_release(C_POR, 0);
        push(5, 1'b0, 1'b0, 1'b0, C_POR);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
